// File: rtl/sha256d_miner.sv
// Double-SHA-256 nonce sweeper around one streaming compression core.
// Optional MIDSTATE_CACHE_EN keeps the first-block digest so later nonces skip the refetch.
module sha256_stream (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         rdy,
    input  logic [31:0]  data,
    output logic [3:0]   addr,
    output logic         rq,
    input  logic [255:0] state_in,
    output logic [255:0] state_out,
    output logic         done
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic [31:0] hin [8];
    logic [31:0] v   [8];
    logic [31:0] nv  [8];
    logic [31:0] w   [16];
    logic [5:0]  idx;
    logic        run;
    logic        adv;
    logic [31:0] wt, t1, t2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Rounds 0..15 consume a bus word each, so they advance only on rdy.
    always_comb begin
        adv = run && ((idx[5:4] != 2'b00) || rdy);
        wt  = (idx[5:4] == 2'b00) ? data :
              (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9] +
              (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        t1  = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
              ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[idx] + wt;
        t2  = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
              ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        nv[0] = t1 + t2;
        nv[1] = v[0];
        nv[2] = v[1];
        nv[3] = v[2];
        nv[4] = v[3] + t1;
        nv[5] = v[4];
        nv[6] = v[5];
        nv[7] = v[6];
    end

    assign rq   = run && (idx[5:4] == 2'b00);
    assign addr = idx[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                hin[i] <= '0;
                v[i]   <= '0;
            end
            for (int i = 0; i < 16; i++) w[i] <= '0;
            idx       <= '0;
            run       <= 1'b0;
            done      <= 1'b0;
            state_out <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                for (int i = 0; i < 8; i++) begin
                    hin[i] <= state_in[(7 - i) * 32 +: 32];
                    v[i]   <= state_in[(7 - i) * 32 +: 32];
                end
                idx <= '0;
                run <= 1'b1;
            end else if (adv) begin
                for (int i = 0; i < 8; i++) v[i] <= nv[i];
                for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
                w[15] <= wt;
                idx   <= idx + 6'd1;
                if (idx == 6'd63) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                    for (int i = 0; i < 8; i++) state_out[(7 - i) * 32 +: 32] <= hin[i] + nv[i];
                end
            end
        end
    end
endmodule

module sha256d_miner #(
    parameter int NONCE_W   = 8,
    parameter int ZERO_BITS = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  nonce_base,
    input  logic         rdy,
    input  logic [31:0]  data,
    output logic [4:0]   addr,
    output logic         rq,
    output logic         busy,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [255:0] hash,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, BLOCK1, BLOCK2, DOUBLE, CHECK} state_t;
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    state_t state, state_nxt;
    logic [31:0] nonce, data_q, core_data, h7_be;
    logic [NONCE_W-1:0] cnt;
    logic [255:0] core_out, core_state_in, chain;
    logic [3:0] core_addr;
    logic core_start, core_start_nxt, core_rdy, core_rq, core_done;
    logic rdy_q, fetch, pass, fin_found, fin_done, latch, step;
`ifdef MIDSTATE_CACHE_EN
    logic [255:0] midstate;
    logic mid_we;
    assign chain = midstate;
`else
    assign chain = core_out;
`endif

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    sha256_stream u_core (
        .clk(clk), .rst_n(rst_n), .start(core_start), .rdy(core_rdy), .data(core_data),
        .addr(core_addr), .rq(core_rq), .state_in(core_state_in), .state_out(core_out), .done(core_done)
    );

    assign h7_be = bswap(core_out[31:0]);
    assign pass  = (h7_be >> (32 - ZERO_BITS)) == 32'd0;
    assign busy  = (state != IDLE);
    assign fetch = (state == BLOCK1) || (state == BLOCK2 && core_addr < 4'd3);
    // A word already registered in rdy_q holds the request low so the bus cannot present it twice.
    assign rq    = fetch && core_rq && !rdy_q && !core_start;
    assign addr  = {1'b0, core_addr} + ((state == BLOCK2) ? 5'd16 : 5'd0);
    assign core_state_in = (state == BLOCK2) ? chain : IV;

    always_comb begin
        core_data = data_q;
        core_rdy  = fetch && rdy_q;
        if (state == BLOCK2 && !fetch) begin
            core_rdy = 1'b1;
            case (core_addr)
                4'd3:    core_data = bswap(nonce);
                4'd4:    core_data = 32'h80000000;
                4'd15:   core_data = 32'h00000280;
                default: core_data = 32'h0;
            endcase
        end else if (state == DOUBLE) begin
            core_rdy = 1'b1;
            if (!core_addr[3])          core_data = core_out[{~core_addr[2:0], 5'd0} +: 32];
            else if (core_addr == 4'd8) core_data = 32'h80000000;
            else if (core_addr == 4'd15) core_data = 32'h00000100;
            else                         core_data = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // core_done is ignored while core_start is high: a block abandoned by abort may still finish then.
    always_comb begin
        state_nxt      = state;
        core_start_nxt = 1'b0;
        fin_found      = 1'b0;
        fin_done       = 1'b0;
        latch          = 1'b0;
        step           = 1'b0;
`ifdef MIDSTATE_CACHE_EN
        mid_we         = 1'b0;
`endif
        case (state)
            IDLE: if (start) begin
                state_nxt = BLOCK1; core_start_nxt = 1'b1; latch = 1'b1;
            end
            BLOCK1: if (core_done && !core_start) begin
                state_nxt = BLOCK2; core_start_nxt = 1'b1;
`ifdef MIDSTATE_CACHE_EN
                mid_we = 1'b1;
`endif
            end
            BLOCK2: if (core_done && !core_start) begin
                state_nxt = DOUBLE; core_start_nxt = 1'b1;
            end
            DOUBLE: if (core_done && !core_start) state_nxt = CHECK;
            CHECK: begin
                if (pass) begin
                    state_nxt = IDLE; fin_found = 1'b1; fin_done = 1'b1;
                end else if (&cnt) begin
                    state_nxt = IDLE; fin_done = 1'b1;
                end else begin
                    step = 1'b1; core_start_nxt = 1'b1;
`ifdef MIDSTATE_CACHE_EN
                    state_nxt = BLOCK2;
`else
                    state_nxt = BLOCK1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE && !(state == CHECK && pass)) begin
            state_nxt = IDLE; core_start_nxt = 1'b0; fin_done = 1'b1; step = 1'b0;
`ifdef MIDSTATE_CACHE_EN
            mid_we = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_start <= 1'b0;
            rdy_q      <= 1'b0;
            data_q     <= '0;
            found      <= 1'b0;
            done       <= 1'b0;
            nonce      <= '0;
            cnt        <= '0;
            nonce_out  <= '0;
            hash       <= '0;
`ifdef MIDSTATE_CACHE_EN
            midstate   <= '0;
`endif
        end else begin
            core_start <= core_start_nxt;
            rdy_q      <= rq && rdy;
            data_q     <= data;
            found      <= fin_found;
            done       <= fin_done;
            if (latch) begin
                nonce <= nonce_base;
                cnt   <= '0;
            end else if (step) begin
                nonce <= nonce + 32'd1;
                cnt   <= cnt + NONCE_W'(1);
            end
            if (fin_found) begin
                nonce_out <= nonce;
                hash      <= core_out;
            end
`ifdef MIDSTATE_CACHE_EN
            if (mid_we) midstate <= core_out;
`endif
        end
    end
endmodule

// File: tb/tb_sha256d_miner.sv
// Randomized self-checking bench for sha256d_miner against a plain double-SHA-256 model.
// Two instances: a (NONCE_W=3, ZERO_BITS=32) and b (NONCE_W=2, ZERO_BITS=1) for nonce wrap.
module tb_sha256d_miner;
    localparam int NW_A = 3, ZB_A = 32, NW_B = 2, ZB_B = 1;
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] GEN_HASH =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [31:0] GEN_HDR [20] = '{
        32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
        32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start_a = 0, abort_a = 0, rdy_a = 0, rq_a, busy_a, found_a, done_a;
    logic [31:0]  nonce_base_a = 0, data_a = 0, nonce_out_a;
    logic [4:0]   addr_a;
    logic [255:0] hash_a;
    logic         start_b = 0, abort_b = 0, rdy_b = 0, rq_b, busy_b, found_b, done_b;
    logic [31:0]  nonce_base_b = 0, data_b = 0, nonce_out_b;
    logic [4:0]   addr_b;
    logic [255:0] hash_b;

    sha256d_miner #(.NONCE_W(NW_A), .ZERO_BITS(ZB_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .nonce_base(nonce_base_a),
        .rdy(rdy_a), .data(data_a), .addr(addr_a), .rq(rq_a), .busy(busy_a), .found(found_a),
        .nonce_out(nonce_out_a), .hash(hash_a), .done(done_a));
    sha256d_miner #(.NONCE_W(NW_B), .ZERO_BITS(ZB_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .nonce_base(nonce_base_b),
        .rdy(rdy_b), .data(data_b), .addr(addr_b), .rq(rq_b), .busy(busy_b), .found(found_b),
        .nonce_out(nonce_out_b), .hash(hash_b), .done(done_b));

    logic [31:0] hdr [2][20];
    int stall_fix = -1;
    int reads [2], rd18 [2], found_cnt [2], done_cnt [2], wait_c [2], stall_cur [2];
    int n_checks = 0, n_pass = 0;
    logic [31:0] exp_q [$];

    // ---------------- bus responders and pulse counters ----------------
    initial begin
        for (int i = 0; i < 2; i++) begin
            reads[i] = 0; rd18[i] = 0; found_cnt[i] = 0; done_cnt[i] = 0; wait_c[i] = 0; stall_cur[i] = 0;
        end
        forever begin
            @(negedge clk);
            rdy_a = 1'b0;
            rdy_b = 1'b0;
            if (rq_a) begin
                if (wait_c[0] >= stall_cur[0]) begin
                    rdy_a = 1'b1; data_a = hdr[0][addr_a]; reads[0]++; wait_c[0] = 0;
                    if (addr_a == 5'd18) rd18[0]++;
                    stall_cur[0] = (stall_fix >= 0) ? stall_fix : $urandom_range(0, 3);
                end else wait_c[0]++;
            end
            if (rq_b) begin
                if (wait_c[1] >= stall_cur[1]) begin
                    rdy_b = 1'b1; data_b = hdr[1][addr_b]; reads[1]++; wait_c[1] = 0;
                    stall_cur[1] = (stall_fix >= 0) ? stall_fix : $urandom_range(0, 3);
                end else wait_c[1]++;
            end
            if (found_a) found_cnt[0]++;
            if (done_a)  done_cnt[0]++;
            if (found_b) found_cnt[1]++;
            if (done_b)  done_cnt[1]++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7] +
                   (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, h} = st;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K_TB[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
                st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
    endfunction

    // Bitcoin header with the nonce replaced, hashed twice.
    function automatic logic [255:0] dsha(input int which, input logic [31:0] nonce);
        logic [511:0] b1, b2, b3;
        logic [255:0] d1;
        for (int i = 0; i < 16; i++) b1[511 - 32 * i -: 32] = hdr[which][i];
        b2 = {hdr[which][16], hdr[which][17], hdr[which][18], bswap(nonce), 32'h80000000, 320'd0, 32'h00000280};
        d1 = compress(compress(IV, b1), b2);
        b3 = {d1, 32'h80000000, 192'd0, 32'h00000100};
        return compress(IV, b3);
    endfunction

    function automatic bit wins(input logic [255:0] dg, input int zb);
        logic [31:0] h7;
        h7 = bswap(dg[31:0]);
        return (h7 >> (32 - zb)) == 32'd0;
    endfunction

    task automatic model_job(input int which, input logic [31:0] base, output bit f,
                             output logic [31:0] n, output logic [255:0] hh, output int tries);
        int nw, zb;
        logic [31:0] nn;
        nw = (which == 0) ? NW_A : NW_B;
        zb = (which == 0) ? ZB_A : ZB_B;
        f = 0; n = 0; hh = 0; tries = 0;
        for (int k = 0; k < (1 << nw) && !f; k++) begin
            nn = base + 32'(k);
            tries++;
            hh = dsha(which, nn);
            if (wins(hh, zb)) begin
                f = 1; n = nn;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic obs_done(input int w);   return (w == 0) ? done_a : done_b;   endfunction
    function automatic logic obs_found(input int w);  return (w == 0) ? found_a : found_b; endfunction
    function automatic logic obs_busy(input int w);   return (w == 0) ? busy_a : busy_b;   endfunction
    function automatic logic [31:0] obs_nonce(input int w); return (w == 0) ? nonce_out_a : nonce_out_b; endfunction
    function automatic logic [255:0] obs_hash(input int w); return (w == 0) ? hash_a : hash_b; endfunction

    // ---------------- driver tasks ----------------
    task automatic load_genesis(input int w);
        for (int i = 0; i < 20; i++) hdr[w][i] = GEN_HDR[i];
    endtask

    task automatic load_random(input int w);
        for (int i = 0; i < 20; i++) hdr[w][i] = $urandom;
    endtask

    task automatic drive_start(input int w, input logic [31:0] base);
        if (w == 0) begin nonce_base_a = base; start_a = 1'b1; end
        else        begin nonce_base_b = base; start_b = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_job(input int w, input logic [31:0] base);
        bit ef, got;
        logic [31:0] en;
        logic [255:0] eh;
        int tries, r0, f0, d0, exp_reads;
        model_job(w, base, ef, en, eh, tries);
        if (ef) exp_q.push_back(en);
`ifdef MIDSTATE_CACHE_EN
        exp_reads = 16 + 3 * tries;
`else
        exp_reads = 19 * tries;
`endif
        r0 = reads[w]; f0 = found_cnt[w]; d0 = done_cnt[w];
        drive_start(w, base);
        check_val("busy_on", obs_busy(w), 1'b1);
        got = 0;
        for (int c = 0; c < 20000 && !got; c++) begin
            if (obs_done(w)) got = 1;
            else @(negedge clk);
        end
        check_val("done_seen", got, 1'b1);
        check_val("found", obs_found(w), ef);
        if (obs_found(w) && exp_q.size() > 0) begin
            check_val("nonce_out", obs_nonce(w), exp_q.pop_front());
            check_val("hash", obs_hash(w), eh);
        end
        @(negedge clk);
        check_val("busy_off", obs_busy(w), 1'b0);
        check_val("done_width", obs_done(w), 1'b0);
        repeat (4) @(negedge clk);
        check_val("found_pulses", found_cnt[w] - f0, ef);
        check_val("done_pulses", done_cnt[w] - d0, 1);
        check_val("bus_reads", reads[w] - r0, exp_reads);
        exp_q.delete();
    endtask

    // ---------------- scenario sequence ----------------
    initial begin
        bit ok;
        int r18, f0, d0;
        load_genesis(0);
        load_genesis(1);
        #1;
        check_val("rst_busy", busy_a, 1'b0);
        check_val("rst_found", found_a, 1'b0);
        check_val("rst_done", done_a, 1'b0);
        check_val("rst_rq", rq_a, 1'b0);
        check_val("rst_addr", addr_a, 5'd0);
        check_val("rst_nonce_out", nonce_out_a, 32'd0);
        check_val("rst_hash", hash_a, 256'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Genesis block: first nonce wins, then one miss before the win.
        run_job(0, 32'h7C2BAC1D);
        check_val("genesis_nonce", nonce_out_a, 32'h7C2BAC1D);
        check_val("genesis_hash", hash_a, GEN_HASH);
        run_job(0, 32'h7C2BAC1C);
        check_val("genesis_nonce_2", nonce_out_a, 32'h7C2BAC1D);

        // Random header: full sweep with no winner expected.
        load_random(0);
        run_job(0, $urandom);

        // Abort during the double hash of the second nonce.
        load_random(0);
        r18 = rd18[0]; f0 = found_cnt[0]; d0 = done_cnt[0];
        drive_start(0, $urandom);
        for (int c = 0; c < 20000 && rd18[0] < r18 + 2; c++) @(negedge clk);
        check_val("abort_reach_nonce2", rd18[0] - r18, 2);
        repeat (90) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_val("abort_done", done_a, 1'b1);
        check_val("abort_found", found_a, 1'b0);
        check_val("abort_busy", busy_a, 1'b0);
        check_val("abort_rq", rq_a, 1'b0);
        repeat (3) @(negedge clk);
        check_val("abort_found_pulses", found_cnt[0] - f0, 0);
        check_val("abort_done_pulses", done_cnt[0] - d0, 1);
        load_genesis(0);
        run_job(0, 32'h7C2BAC1D);

        // Five-cycle bus stalls, winner on the fourth nonce.
        stall_fix = 5;
        run_job(0, 32'h7C2BAC1A);
        check_val("stall_nonce", nonce_out_a, 32'h7C2BAC1D);
        stall_fix = -1;

        // Nonce wrap: pick a header where FFFFFFFF misses and 00000000 wins.
        ok = 0;
        for (int t = 0; t < 64 && !ok; t++) begin
            load_random(1);
            if (!wins(dsha(1, 32'hFFFFFFFF), ZB_B) && wins(dsha(1, 32'h0), ZB_B)) ok = 1;
        end
        run_job(1, 32'hFFFFFFFF);
        check_val("wrap_nonce", nonce_out_b, 32'h0);

        // Reset in the middle of a job: no done pulse.
        load_random(0);
        drive_start(0, $urandom);
        repeat (150) @(negedge clk);
        d0 = done_cnt[0];
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", busy_a, 1'b0);
        check_val("midrst_rq", rq_a, 1'b0);
        check_val("midrst_hash", hash_a, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("midrst_done_pulses", done_cnt[0] - d0, 0);
        check_val("midrst_idle", busy_a, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sha256d_miner.md
SHA256D_MINER -- requirements
Module: sha256d_miner

Interface
REQ-001 Parameter NONCE_W, default 8: width of per-job nonce sweep counter; range 1..32; job covers 2^NONCE_W nonces.
REQ-002 Parameter ZERO_BITS, default 16: required leading zero bits of target check; range 1..32.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin job when idle.
REQ-006 abort  input  1  terminate running job.
REQ-007 nonce_base  input  32  first nonce of job, sampled on accepted start.
REQ-008 rdy  input  1  bus data valid for current addr.
REQ-009 data  input  32  header word at addr, big-endian word order.
REQ-010 addr  output  5  header word index 0..19.
REQ-011 rq  output  1  bus request; high while waiting for header word.
REQ-012 busy  output  1  job in progress.
REQ-013 found  output  1  one-cycle pulse, winning nonce found.
REQ-014 nonce_out  output  32  winning nonce, valid from found pulse until next start.
REQ-015 hash  output  256  final digest of winning nonce, same validity as nonce_out.
REQ-016 done  output  1  one-cycle pulse, job ended (found, exhausted or aborted).

Function
REQ-017 Instantiates one sha256_stream core (start, rdy, data, 4-bit addr, rq, state_in, state_out, done); no second hash core.
REQ-018 States: IDLE, BLOCK1, BLOCK2, DOUBLE, CHECK; 3-bit encoding.
REQ-019 IDLE: start=1 latches nonce_base into nonce, clears sweep counter, asserts busy, loads IV (H0..H7), enters BLOCK1; start ignored in any other state.
REQ-020 BLOCK1: core fetches words 0..15 via bus, addr={0,core_addr}; rq follows core rq; core rdy=rdy registered one cycle.
REQ-021 BLOCK2: chain state = block1 output; words 0..2 from bus at addr 16..18; word 3 = byte-swapped current nonce (no bus access); word 4 = 32'h80000000; word 15 = 32'h00000280; others zero; rq low for words 3..15.
REQ-022 DOUBLE: IV reloaded; words 0..7 = block2 digest; word 8 = 32'h80000000; word 15 = 32'h00000100; others zero; rq low.
REQ-023 CHECK (one cycle): pass if top ZERO_BITS of byte-swapped hash word H7 (digest[31:0]) are all zero.
REQ-024 Pass: latch nonce_out, hash; pulse found and done same cycle; busy low next cycle; enter IDLE.
REQ-025 Fail, counter below 2^NONCE_W-1: nonce+1 (mod 2^32, wraps 32'hFFFFFFFF->0), counter+1, next state per REQ-032/033.
REQ-026 Fail, counter = 2^NONCE_W-1: pulse done only; found stays low; enter IDLE.
REQ-027 Pass on final nonce: found and done both pulse; REQ-024 takes priority over REQ-026.
REQ-028 abort=1 in any non-IDLE state: next cycle IDLE, rq low, done pulse, no found, core restarted on next job; abort coincident with pass in CHECK: pass wins.
REQ-029 Core start held high exactly one cycle per block; core done observed only in matching state.
REQ-030 Throughput per nonce: 2 core blocks (cached) or 3 (uncached) plus 1 CHECK cycle; bus stalls (rdy low) extend only fetch phases.

Reset
REQ-031 rst_n low: state IDLE, busy/found/done/rq 0, addr 0, nonce_out 0, hash 0, counter 0, core start/rdy 0; effective mid-job, no done pulse.

Configuration
REQ-032 Macro MIDSTATE_CACHE_EN defined: block1 digest stored once per job in 256-bit midstate register; subsequent nonces go CHECK->BLOCK2 directly with state_in=midstate.
REQ-033 Macro undefined: no midstate register; every nonce goes CHECK->BLOCK1 and refetches words 0..15; results identical, only latency differs.

Verification
REQ-034 Genesis header (80 bytes), nonce_base=32'h7C2BAC1D, NONCE_W=1, ZERO_BITS=32 -> found on first nonce, nonce_out=32'h7C2BAC1D, hash=genesis double-SHA digest.
REQ-035 Same header, nonce_base=32'h7C2BAC1C, NONCE_W=2 -> one miss then found, nonce_out=32'h7C2BAC1D, exactly one found and one done pulse.
REQ-036 Random header, ZERO_BITS=32, NONCE_W=3, no winner -> 8 nonces tried, done pulse, found never high, busy low after.
REQ-037 nonce_base=32'hFFFFFFFF, NONCE_W=2 -> second nonce hashed is 32'h00000000 (checked vs software model).
REQ-038 abort asserted in DOUBLE of nonce 2 -> IDLE next cycle, done pulse, no found; new start then completes correctly.
REQ-039 rdy held low 5 cycles per fetch, run with and without MIDSTATE_CACHE_EN -> identical nonce_out/hash; uncached run shows 16 extra bus reads per extra nonce.
